// File: rtl/i2c_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sclk_gen
// Description : Free-running I2C SCL generator. Divides clk down to a 50%-duty
//               SCL and emits registered single-cycle phase strobes: SCL rise,
//               SCL fall, mid-high (SDA sample point) and mid-low (SDA change
//               point).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sclk_gen #(
    parameter int CLK_FREQ_HZ = 500_000_000,
    parameter int SCL_FREQ_HZ = 400_000
) (
    input  logic clk,
    input  logic rst_,
    output logic scl,
    output logic scl_rise,
    output logic scl_fall,
    output logic scl_hi_mid,
    output logic scl_lo_mid
);

    // clk cycles per SCL half-period
    localparam int HALF  = CLK_FREQ_HZ / (2 * SCL_FREQ_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(HALF / 2);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // A half-period shorter than two cycles would make strobes collide.
    generate
        if (HALF < 2) begin : g_half_check
            $error("i2c_sclk_gen: HALF=%0d is illegal, must be >= 2", HALF);
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_scl;
    logic             r_scl_rise;
    logic             r_scl_fall;
    logic             r_scl_hi_mid;
    logic             r_scl_lo_mid;

    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_scl_nxt;
    logic             w_mid;

    // Next-state of the divider: wrap at HALF-1 and toggle SCL on the wrap.
    // The mid point is judged on the updated count so the strobe lines up
    // with the register update that produces it.
    always_comb begin
        w_wrap    = (r_cnt == C_CNT_LAST);
        w_cnt_nxt = w_wrap ? '0 : (r_cnt + C_CNT_ONE);
        w_scl_nxt = w_wrap ? ~r_scl : r_scl;
        w_mid     = (w_cnt_nxt == C_CNT_MID);
    end

    // Divider counter, SCL level and all strobes; reset parks SCL at the idle
    // bus level (high) and restarts the first high phase from scratch.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt        <= '0;
            r_scl        <= 1'b1;
            r_scl_rise   <= 1'b0;
            r_scl_fall   <= 1'b0;
            r_scl_hi_mid <= 1'b0;
            r_scl_lo_mid <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_scl        <= w_scl_nxt;
            r_scl_rise   <= w_wrap & ~r_scl;
            r_scl_fall   <= w_wrap &  r_scl;
            r_scl_hi_mid <= w_mid  &  w_scl_nxt;
            r_scl_lo_mid <= w_mid  & ~w_scl_nxt;
        end
    end

    assign scl        = r_scl;
    assign scl_rise   = r_scl_rise;
    assign scl_fall   = r_scl_fall;
    assign scl_hi_mid = r_scl_hi_mid;
    assign scl_lo_mid = r_scl_lo_mid;

endmodule
`default_nettype wire

// File: tb/tb_i2c_sclk_gen.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_i2c_sclk_gen
// Description : Self-checking bench for i2c_sclk_gen. Three instances
//               (HALF=5, HALF=625 defaults, HALF=2) share clk and rst_; every
//               cycle each output vector is compared with an arithmetic model
//               derived from the number of clk edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_sclk_gen;

    logic clk = 1'b1;
    logic rst_;
    logic en;
    int   k;            // rising clk edges since reset release
    int   n_chk;
    int   n_fail;

    logic scl_a, rise_a, fall_a, him_a, lom_a;
    logic scl_b, rise_b, fall_b, him_b, lom_b;
    logic scl_c, rise_c, fall_c, him_c, lom_c;

    // 500 MHz clock, rising edges at 2, 4, 6, ... ns
    always #1 clk = ~clk;

    // HALF = 500e6 / (2 * 50e6) = 5
    i2c_sclk_gen #(.CLK_FREQ_HZ(500_000_000), .SCL_FREQ_HZ(50_000_000)) u_dut_h5 (
        .clk(clk), .rst_(rst_), .scl(scl_a), .scl_rise(rise_a), .scl_fall(fall_a),
        .scl_hi_mid(him_a), .scl_lo_mid(lom_a));

    // Defaults: HALF = 625
    i2c_sclk_gen u_dut_h625 (
        .clk(clk), .rst_(rst_), .scl(scl_b), .scl_rise(rise_b), .scl_fall(fall_b),
        .scl_hi_mid(him_b), .scl_lo_mid(lom_b));

    // HALF = 500e6 / (2 * 125e6) = 2
    i2c_sclk_gen #(.CLK_FREQ_HZ(500_000_000), .SCL_FREQ_HZ(125_000_000)) u_dut_h2 (
        .clk(clk), .rst_(rst_), .scl(scl_c), .scl_rise(rise_c), .scl_fall(fall_c),
        .scl_hi_mid(him_c), .scl_lo_mid(lom_c));

    // Elapsed-time reference: edges counted since rst_ last went high
    always @(posedge clk or negedge rst_) begin
        if (!rst_) k <= 0;
        else       k <= k + 1;
    end

    // Expected {scl, rise, fall, hi_mid, lo_mid} after n edges with half-period h
    function automatic logic [4:0] model(input int h, input int n, input logic rst_now);
        int   per;
        logic s, r, f, m;
        if (!rst_now) return 5'b10000;
        per = 2 * h;
        s   = ((n / h) % 2) == 0;
        r   = (n > 0) && ((n % per) == 0);
        f   = (n % per) == h;
        m   = (n > 0) && ((n % h) == (h / 2));
        return {s, r, f, m & s, m & ~s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sample half a clk after each rising edge
    always @(posedge clk) begin
        #0.5;
        if (en) begin
            check("h5",   {27'd0, scl_a, rise_a, fall_a, him_a, lom_a}, {27'd0, model(5,   k, rst_)});
            check("h625", {27'd0, scl_b, rise_b, fall_b, him_b, lom_b}, {27'd0, model(625, k, rst_)});
            check("h2",   {27'd0, scl_c, rise_c, fall_c, him_c, lom_c}, {27'd0, model(2,   k, rst_)});
        end
    end

    initial begin
        int extra;
        n_chk  = 0;
        n_fail = 0;
        en     = 1'b0;
        rst_   = 1'b1;
        #7;
        rst_   = 1'b0;
        en     = 1'b1;
        #2;
        rst_   = 1'b1;                       // released at 9 ns, between edges

        // Run a while with randomized length, then land mid-low on HALF=5
        extra = int'($urandom_range(40, 80));
        repeat (extra) @(posedge clk);
        #0.1;
        for (int i = 0; i < 20 && (k % 10) != 7; i++) begin
            @(posedge clk);
            #0.1;
        end
        check("find_mid_low", k % 10, 7);
        check("h5_low_before_rst", {31'd0, scl_a}, 32'd0);

        // Asynchronous reset between edges: outputs clear without a clk edge
        #1.0;
        rst_ = 1'b0;
        #0.3;
        check("async_h5",   {27'd0, scl_a, rise_a, fall_a, him_a, lom_a}, 32'h10);
        check("async_h625", {27'd0, scl_b, rise_b, fall_b, him_b, lom_b}, 32'h10);
        check("async_h2",   {27'd0, scl_c, rise_c, fall_c, him_c, lom_c}, 32'h10);

        // Hold reset a random few cycles, release between edges
        extra = int'($urandom_range(2, 5));
        repeat (extra) @(posedge clk);
        #1.2;
        rst_ = 1'b1;

        // Long enough for two full HALF=625 periods
        repeat (2600) @(posedge clk);
        #0.8;
        en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
